// File: rtl/checkbits_scoreboard.sv
// Decodes the firmware marker protocol on the checkbits bus, times run phases, scores check phases against a golden table.
// Latency: a bus value is accepted STABLE+1 cycles after it first appears; status outputs update on the accept cycle.
// Backpressure: none; the bus is sampled every cycle, and values that do not hold STABLE cycles are dropped.
module checkbits_scoreboard #(
    parameter int              CB_W       = 16,
    parameter int              N_WL       = 3,
    parameter int              MAX_RES    = 64,
    parameter logic [N_WL-1:0] SPLIT_MASK = 3'b001,
    parameter logic [7:0]      MARK_HI    = 8'hAB,
    parameter int              CHK_BASE   = 3,
    parameter int              STABLE     = 4,
    parameter int              TIMEOUT    = 250000,
    localparam int             WL_W       = (N_WL > 1) ? $clog2(N_WL) : 1,
    localparam int             IDX_W      = $clog2(MAX_RES),
    localparam int             SW         = $clog2(STABLE + 1)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [CB_W-1:0]   checkbits,
    input  logic              gold_we,
    input  logic [WL_W-1:0]   gold_wl,
    input  logic [IDX_W-1:0]  gold_idx,
    input  logic [31:0]       gold_data,
    input  logic              gold_len_we,
    input  logic [WL_W-1:0]   rd_wl,
    output logic [31:0]       cyc_out,
    output logic [6:0]        fail_idx,
    output logic [N_WL-1:0]   wl_done,
    output logic [N_WL-1:0]   wl_pass,
    output logic              busy,
    output logic              ev_pulse,
    output logic              timeout
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

    state_t            state, nxt_state;
    logic [CB_W-1:0]   cand_q, last_acc;
    logic [SW-1:0]     stab_cnt;
    logic [WL_W-1:0]   act_wl;
    logic [6:0]        idx;
    logic              half, mism;
    logic [31:0]       gold  [N_WL][MAX_RES];
    logic [6:0]        len   [N_WL];
    logic [31:0]       cyc   [N_WL];
    logic [6:0]        fail_r[N_WL];
    logic [31:0]       wd;

    logic              acc, is_mark, run_hit, chk_hit, in_data, split, wd_hit;
    logic [31:0]       nib32, g;
    logic [WL_W-1:0]   run_wl, chk_wl;
    logic [CB_W-1:0]   exp_val, run_end_val, chk_end_val;
    logic              go_run, go_chk, data_step, end_ok, extra_mism;

    // A value is accepted once it has held STABLE cycles and differs from the previous accepted value.
    assign acc     = (stab_cnt == SW'(STABLE)) && (cand_q != last_acc);
    assign is_mark = (cand_q[CB_W-1 -: 8] == MARK_HI) && (cand_q[3:0] == 4'h0);
    assign nib32   = {28'd0, cand_q[7:4]};
    assign run_hit = is_mark && (nib32 < 32'(N_WL));
    assign chk_hit = is_mark && (nib32 >= 32'(CHK_BASE)) && (nib32 < 32'(CHK_BASE + N_WL));
    assign run_wl  = WL_W'(nib32);
    assign chk_wl  = WL_W'(nib32 - 32'(CHK_BASE));

    assign run_end_val = CB_W'({MARK_HI, 4'(act_wl), 4'h1});
    assign chk_end_val = CB_W'({MARK_HI, 4'(32'(act_wl) + 32'(CHK_BASE)), 4'h1});

    assign in_data = idx < len[act_wl];
    assign split   = SPLIT_MASK[act_wl];
    assign g       = gold[act_wl][idx[IDX_W-1:0]];
    assign exp_val = split ? (half ? CB_W'(g[15:0]) : CB_W'(g[31:16])) : g[CB_W-1:0];
    assign wd_hit  = (state != IDLE) && !acc && (wd >= 32'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= nxt_state;
    end

    always_comb begin
        nxt_state  = state;
        go_run     = 1'b0;
        go_chk     = 1'b0;
        data_step  = 1'b0;
        end_ok     = 1'b0;
        extra_mism = 1'b0;
        case (state)
            IDLE: begin
                if (acc && run_hit) begin
                    nxt_state = RUN;
                    go_run    = 1'b1;
                end else if (acc && chk_hit) begin
                    nxt_state = CHECK;
                    go_chk    = 1'b1;
                end
            end
            RUN: begin
                if (acc && cand_q == run_end_val) nxt_state = IDLE;
            end
            CHECK: begin
                if (acc) begin
                    // Until the table is exhausted every value is data, even marker-looking ones.
                    if (in_data) begin
                        data_step = 1'b1;
                    end else if (cand_q == chk_end_val) begin
                        end_ok    = 1'b1;
                        nxt_state = IDLE;
                    end else begin
                        extra_mism = 1'b1;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (wd_hit) nxt_state = IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cand_q   <= '0;
            stab_cnt <= '0;
            last_acc <= '0;
            ev_pulse <= 1'b0;
            act_wl   <= '0;
            idx      <= '0;
            half     <= 1'b0;
            mism     <= 1'b0;
            wd       <= '0;
            timeout  <= 1'b0;
            wl_done  <= '0;
            wl_pass  <= '0;
            for (int w = 0; w < N_WL; w++) begin
                len[w]    <= '0;
                cyc[w]    <= '0;
                fail_r[w] <= 7'h7F;
                for (int i = 0; i < MAX_RES; i++) gold[w][i] <= '0;
            end
        end else begin
            cand_q <= checkbits;
            if (checkbits != cand_q)         stab_cnt <= SW'(1);
            else if (stab_cnt != SW'(STABLE)) stab_cnt <= stab_cnt + SW'(1);
            ev_pulse <= acc;
            if (acc) last_acc <= cand_q;

            if (gold_we && 32'(gold_wl) < 32'(N_WL))     gold[gold_wl][gold_idx] <= gold_data;
            if (gold_len_we && 32'(gold_wl) < 32'(N_WL)) len[gold_wl] <= gold_data[6:0];

            if (state == IDLE || acc)   wd <= '0;
            else if (wd != 32'hFFFF_FFFF) wd <= wd + 32'd1;
            if (wd_hit) timeout <= 1'b1;

            if (state == RUN && cyc[act_wl] != 32'hFFFF_FFFF) cyc[act_wl] <= cyc[act_wl] + 32'd1;

            if (go_run) begin
                act_wl      <= run_wl;
                cyc[run_wl] <= '0;
            end
            if (go_chk) begin
                act_wl          <= chk_wl;
                idx             <= '0;
                half            <= 1'b0;
                mism            <= 1'b0;
                fail_r[chk_wl]  <= 7'h7F;
                wl_done[chk_wl] <= 1'b0;
                wl_pass[chk_wl] <= 1'b0;
            end
            if (data_step) begin
                if (cand_q != exp_val) begin
                    mism <= 1'b1;
                    if (fail_r[act_wl] == 7'h7F) fail_r[act_wl] <= idx;
                end
                if (split && !half) begin
                    half <= 1'b1;
                end else begin
                    half <= 1'b0;
                    idx  <= idx + 7'd1;
                end
            end
            if (extra_mism) begin
                mism <= 1'b1;
                if (fail_r[act_wl] == 7'h7F) fail_r[act_wl] <= len[act_wl];
            end
            if (end_ok) begin
                wl_done[act_wl] <= 1'b1;
                wl_pass[act_wl] <= !mism;
            end
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        cyc_out  = '0;
        fail_idx = 7'h7F;
        if (32'(rd_wl) < 32'(N_WL)) begin
            cyc_out  = cyc[rd_wl];
            fail_idx = fail_r[rd_wl];
        end
    end

endmodule

// File: tb/tb_checkbits_scoreboard.sv
// Directed bench for checkbits_scoreboard: marker protocol, golden compare, run timing, glitch, watchdog and reset.
module tb_checkbits_scoreboard;

    localparam int TMO = 3000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [15:0] checkbits = '0;
    logic        gold_we = 1'b0;
    logic [1:0]  gold_wl = '0;
    logic [5:0]  gold_idx = '0;
    logic [31:0] gold_data = '0;
    logic        gold_len_we = 1'b0;
    logic [1:0]  rd_wl = '0;
    logic [31:0] cyc_out;
    logic [6:0]  fail_idx;
    logic [2:0]  wl_done, wl_pass;
    logic        busy, ev_pulse, timeout;

    int n_chk = 0;
    int n_err = 0;
    int ev_cnt = 0;
    int base;

    checkbits_scoreboard #(.TIMEOUT(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .checkbits(checkbits),
        .gold_we(gold_we), .gold_wl(gold_wl), .gold_idx(gold_idx), .gold_data(gold_data),
        .gold_len_we(gold_len_we), .rd_wl(rd_wl), .cyc_out(cyc_out), .fail_idx(fail_idx),
        .wl_done(wl_done), .wl_pass(wl_pass), .busy(busy), .ev_pulse(ev_pulse), .timeout(timeout)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // ev_pulse is registered, so sampling on the rising edge counts each pulse exactly once.
    always @(posedge wb_clk_i) if (ev_pulse) ev_cnt <= ev_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] v);
        @(negedge wb_clk_i);
        checkbits = v;
        repeat (6) @(negedge wb_clk_i);
    endtask

    task automatic load(input logic [1:0] wl, input logic [5:0] i, input logic [31:0] d);
        @(negedge wb_clk_i);
        gold_we = 1'b1; gold_wl = wl; gold_idx = i; gold_data = d;
        @(negedge wb_clk_i);
        gold_we = 1'b0;
    endtask

    task automatic load_len(input logic [1:0] wl, input logic [6:0] n);
        @(negedge wb_clk_i);
        gold_len_we = 1'b1; gold_wl = wl; gold_data = {25'd0, n};
        @(negedge wb_clk_i);
        gold_len_we = 1'b0;
    endtask

    function automatic logic [31:0] fir_gold(input int i);
        if (i == 1) return -32'sd10;
        return {16'hF000 + 16'(i), 16'h0100 + 16'(i)};
    endfunction

    logic [31:0] qs [5] = '{32'd40, 32'd893, 32'd12, -32'sd5, 32'd700};
    logic [31:0] y;

    initial begin
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst_done", 32'(wl_done), 0);
        check("rst_pass", 32'(wl_pass), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_ev", 32'(ev_pulse), 0);
        check("rst_fail_idx", 32'(fail_idx), 32'h7F);
        check("rst_cyc", cyc_out, 0);

        // Empty table: end marker right after start passes.
        send(16'hAB40);
        check("len0_busy", 32'(busy), 1);
        send(16'hAB41);
        check("len0_done", 32'(wl_done[1]), 1);
        check("len0_pass", 32'(wl_pass[1]), 1);
        check("len0_idle", 32'(busy), 0);

        // FIR: 64 split results, 128 halves.
        for (int i = 0; i < 64; i++) load(2'd0, 6'(i), fir_gold(i));
        load_len(2'd0, 7'd64);
        rd_wl = 2'd0;
        send(16'hAB30);
        base = ev_cnt;
        for (int i = 0; i < 64; i++) begin
            y = fir_gold(i);
            send(y[31:16]);
            send(y[15:0]);
        end
        check("fir_ev_count", 32'(ev_cnt - base), 128);
        check("fir_not_done", 32'(wl_done[0]), 0);
        send(16'hAB31);
        check("fir_done", 32'(wl_done[0]), 1);
        check("fir_pass", 32'(wl_pass[0]), 1);
        check("fir_fail_idx", 32'(fail_idx), 32'h7F);

        // Matmul: 16 results, #5 and #9 wrong; first mismatch is reported.
        for (int i = 0; i < 16; i++) load(2'd1, 6'(i), 32'(56 + 3 * i));
        load_len(2'd1, 7'd16);
        rd_wl = 2'd1;
        send(16'hAB40);
        for (int i = 0; i < 16; i++)
            send(i == 5 ? 16'h7777 : i == 9 ? 16'h5555 : 16'(56 + 3 * i));
        check("mm_not_done", 32'(wl_done[1]), 0);
        send(16'hAB41);
        check("mm_done", 32'(wl_done[1]), 1);
        check("mm_pass", 32'(wl_pass[1]), 0);
        check("mm_fail_idx", 32'(fail_idx), 5);

        // Run timing: end marker driven 1000 cycles after start marker.
        rd_wl = 2'd0;
        send(16'hAB00);
        check("run_busy", 32'(busy), 1);
        repeat (993) @(negedge wb_clk_i);
        send(16'hAB01);
        check("run_cyc_in_range", 32'(cyc_out >= 32'd995 && cyc_out <= 32'd1005), 1);
        check("run_idle", 32'(busy), 0);
        check("run_fir_kept", 32'(wl_pass[0]), 1);

        // qsort with a 2-cycle spike between 40 and 893.
        for (int i = 0; i < 5; i++) load(2'd2, 6'(i), qs[i]);
        load_len(2'd2, 7'd5);
        rd_wl = 2'd2;
        send(16'hAB50);
        send(qs[0][15:0]);
        base = ev_cnt;
        @(negedge wb_clk_i);
        checkbits = 16'h0BAD;
        repeat (2) @(negedge wb_clk_i);
        checkbits = qs[0][15:0];
        repeat (6) @(negedge wb_clk_i);
        check("glitch_no_ev", 32'(ev_cnt - base), 0);
        send(qs[1][15:0]);
        check("glitch_next_ev", 32'(ev_cnt - base), 1);
        for (int i = 2; i < 5; i++) send(qs[i][15:0]);
        send(16'hAB51);
        check("qs_done", 32'(wl_done[2]), 1);
        check("qs_pass", 32'(wl_pass[2]), 1);
        check("qs_fail_idx", 32'(fail_idx), 32'h7F);

        // Watchdog: enter check, then freeze the bus.
        send(16'hAB50);
        check("tmo_cleared_done", 32'(wl_done[2]), 0);
        check("tmo_not_yet", 32'(timeout), 0);
        repeat (TMO + 10) @(negedge wb_clk_i);
        check("tmo_flag", 32'(timeout), 1);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_done", 32'(wl_done[2]), 0);
        check("tmo_pass", 32'(wl_pass[2]), 0);
        checkbits = 16'h0000;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        check("tmo_rst_clear", 32'(timeout), 0);
        check("tmo_rst_done", 32'(wl_done), 0);

        // Reset mid-check: table length is 0 after reset, so every value mismatches at index 0.
        rd_wl = 2'd1;
        send(16'hAB40);
        send(16'h0011);
        send(16'h0022);
        send(16'h0033);
        check("mid_busy", 32'(busy), 1);
        check("mid_fail_idx", 32'(fail_idx), 0);
        @(negedge wb_clk_i);
        checkbits = 16'h0000;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(wl_done), 0);
        check("mid_rst_fail_idx", 32'(fail_idx), 32'h7F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
